// File: rtl/mda_pixel_pipe_if.sv
// Pixel pipe bus: position inputs, text VRAM and font ROM fetch ports, pixel outputs.
// The cursor signals are present only when MDA_CURSOR_EN is defined.
// The slave modport is the pipe's view; the master modport is the view of the
// character counter, memories and DAC around it.
interface mda_pixel_pipe_if;
   logic        enable;
   logic [6:0]  col;
   logic [4:0]  row;
   logic [3:0]  char_row;
   logic [3:0]  char_pixel;
   logic [10:0] vram_addr;
   logic [15:0] vram_data;
   logic [11:0] font_addr;
   logic [7:0]  font_data;
   logic        video;
   logic        intense;
   logic        de_out;
`ifdef MDA_CURSOR_EN
   logic [6:0]  cursor_col;
   logic [4:0]  cursor_row;
   logic [3:0]  cursor_start;
   logic [3:0]  cursor_end;
`endif

   modport slave (
      input  enable, col, row, char_row, char_pixel, vram_data, font_data,
`ifdef MDA_CURSOR_EN
      input  cursor_col, cursor_row, cursor_start, cursor_end,
`endif
      output vram_addr, font_addr, video, intense, de_out
   );

   modport master (
      output enable, col, row, char_row, char_pixel, vram_data, font_data,
`ifdef MDA_CURSOR_EN
      output cursor_col, cursor_row, cursor_start, cursor_end,
`endif
      input  vram_addr, font_addr, video, intense, de_out
   );
endinterface

// File: rtl/mda_pixel_pipe.sv
// MDA pixel pipe: character position -> VRAM fetch -> font fetch -> monochrome pixel.
// Fixed three-clock latency from enable to de_out/video, one pixel per clock.
// Optional hardware cursor overlay is built when MDA_CURSOR_EN is defined.
module mda_pixel_pipe #(
   parameter int COLS    = 80,
   parameter int UL_ROW  = 12,
   parameter int BLINK_B = 4
) (
   input logic             clk,
   input logic             rst_n,
   mda_pixel_pipe_if.slave bus
);

   logic [10:0] cell_addr;
   logic        frame_tick;
   logic [4:0]  frame_cnt;
   logic        blink_phase;

   logic        v1;
   logic [3:0]  cr_d1;
   logic [3:0]  px_d1;
   logic        blink_d1;

   logic        v2;
   logic [3:0]  cr_d2;
   logic [3:0]  px_d2;
   logic        blink_d2;
   logic [7:0]  attr_d2;
   logic        box_d2;

   logic        glyph;
   logic        fg_blank;
   logic        video_next;
   logic        intense_next;

   // Cell address is plain arithmetic truncated to the VRAM word width; the
   // constant multiply reduces to a shift-add.
   assign cell_addr  = 11'(32'(bus.row) * 32'(COLS) + 32'(bus.col));
   assign frame_tick = bus.enable && (bus.col == 7'd0) && (bus.row == 5'd0) &&
                       (bus.char_row == 4'd0) && (bus.char_pixel == 4'd0);

   // S0: issue the VRAM address and count frames; blink phase is latched at the
   // first pixel of each frame so it stays constant for the whole frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.vram_addr <= '0;
         v1            <= 1'b0;
         cr_d1         <= '0;
         px_d1         <= '0;
         blink_d1      <= 1'b0;
         frame_cnt     <= '0;
         blink_phase   <= 1'b0;
      end else begin
         bus.vram_addr <= cell_addr;
         v1            <= bus.enable;
         cr_d1         <= bus.char_row;
         px_d1         <= bus.char_pixel;
         blink_d1      <= frame_tick ? frame_cnt[BLINK_B] : blink_phase;
         if (frame_tick) begin
            frame_cnt   <= frame_cnt + 5'd1;
            blink_phase <= frame_cnt[BLINK_B];
         end
      end
   end

   // S1: VRAM word arrives; issue the font address and hold the attribute.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.font_addr <= '0;
         attr_d2       <= '0;
         box_d2        <= 1'b0;
         v2            <= 1'b0;
         cr_d2         <= '0;
         px_d2         <= '0;
         blink_d2      <= 1'b0;
      end else begin
         bus.font_addr <= {bus.vram_data[7:0], cr_d1};
         attr_d2       <= bus.vram_data[15:8];
         box_d2        <= (bus.vram_data[7:5] == 3'b110);
         v2            <= v1;
         cr_d2         <= cr_d1;
         px_d2         <= px_d1;
         blink_d2      <= blink_d1;
      end
   end

`ifdef MDA_CURSOR_EN
   logic cur_phase;
   logic cur_hit_d1;
   logic cur_ph_d1;
   logic cur_hit_d2;
   logic cur_ph_d2;
   logic cursor_on;

   // Cursor cell match and cursor blink phase travel down the pipe with the pixel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_phase  <= 1'b0;
         cur_hit_d1 <= 1'b0;
         cur_ph_d1  <= 1'b0;
         cur_hit_d2 <= 1'b0;
         cur_ph_d2  <= 1'b0;
      end else begin
         cur_hit_d1 <= (bus.col == bus.cursor_col) && (bus.row == bus.cursor_row);
         cur_ph_d1  <= frame_tick ? frame_cnt[3] : cur_phase;
         if (frame_tick) cur_phase <= frame_cnt[3];
         cur_hit_d2 <= cur_hit_d1;
         cur_ph_d2  <= cur_ph_d1;
      end
   end

   assign cursor_on = cur_hit_d2 && cur_ph_d2 &&
                      (bus.cursor_start <= cr_d2) && (cr_d2 <= bus.cursor_end);
`endif

   // S2 decode: glyph bit select, then MDA attribute rules and blink.
   always_comb begin
      glyph = 1'b0;
      if (!px_d2[3]) glyph = bus.font_data[3'd7 - px_d2[2:0]];
      else           glyph = box_d2 & bus.font_data[0];
      fg_blank   = attr_d2[7] & blink_d2;
      video_next = 1'b0;
      if (attr_d2[2:0] == 3'b000) begin
         if (attr_d2[6:4] == 3'b111) video_next = fg_blank | ~glyph;
         else                        video_next = 1'b0;
      end else if (attr_d2[2:0] == 3'b001) begin
         video_next = ~fg_blank & (glyph | (cr_d2 == 4'(UL_ROW)));
      end else begin
         video_next = ~fg_blank & glyph;
      end
`ifdef MDA_CURSOR_EN
      if (cursor_on) video_next = 1'b1;
`endif
      intense_next = attr_d2[3] & video_next;
   end

   // S2 output register; border periods are forced black.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.video   <= 1'b0;
         bus.intense <= 1'b0;
         bus.de_out  <= 1'b0;
      end else if (v2) begin
         bus.video   <= video_next;
         bus.intense <= intense_next;
         bus.de_out  <= 1'b1;
      end else begin
         bus.video   <= 1'b0;
         bus.intense <= 1'b0;
         bus.de_out  <= 1'b0;
      end
   end

endmodule
